// File: rtl/ddr3_phy_pkg.sv
// rtl/ddr3_phy_pkg.sv - shared widths, latencies and command bundle for the generic DDR3 PHY
package ddr3_phy_pkg;

  localparam int DQ_WIDTH       = 16;
  localparam int DM_WIDTH       = DQ_WIDTH / 8;
  localparam int DFI_DATA_WIDTH = 2 * DQ_WIDTH;
  localparam int DFI_MASK_WIDTH = DQ_WIDTH / 4;
  localparam int ADDR_WIDTH     = 14;

  localparam int PHY_WR_DELAY   = 1;
  localparam int PHY_RD_DELAY   = 1;

  localparam int BL8_WORDS      = 4;
  localparam int WORD_CNT_BITS  = $clog2(BL8_WORDS);

  typedef struct packed {
    logic       rst_n;
    logic       cke;
    logic       cs_n;
    logic       ras_n;
    logic       cas_n;
    logic       we_n;
    logic       odt;
    logic [2:0] ba;
  } cmd_ctl_t;

  localparam cmd_ctl_t CMD_RESET = '{rst_n: 1'b0, cke: 1'b0, cs_n: 1'b1, ras_n: 1'b1,
                                     cas_n: 1'b1, we_n: 1'b1, odt: 1'b0, ba: 3'd0};

endpackage

// File: rtl/ddr_io_bit.sv
// rtl/ddr_io_bit.sv - one DDR pad: rise/fall output register, enable register and negedge capture
module ddr_io_bit (
  input  logic clock,
  input  logic d_rise,
  input  logic d_fall,
  input  logic oe,
  input  logic hold_off,
  input  logic pad_in,
  output logic pad_out,
  output logic pad_en,
  output logic cap_neg
);

  logic rise_q;
  logic fall_q;
  logic oe_q;

  always_ff @(posedge clock) begin
    rise_q <= d_rise;
    fall_q <= d_fall;
    oe_q   <= oe;
  end

  // Rise value is presented while clock is high, fall value while it is low.
  assign pad_out = clock ? rise_q : fall_q;
  assign pad_en  = oe_q & ~hold_off;

  always_ff @(negedge clock) begin
    cap_neg <= pad_in;
  end

endmodule

// File: rtl/ddr3_phy_generic.sv
// rtl/ddr3_phy_generic.sv - vendor-neutral x16 DDR3 PHY between a DFI port and the SDRAM pins
module ddr3_phy_generic
  import ddr3_phy_pkg::*;
#(
  parameter int DDR3_WIDTH = DQ_WIDTH,
  parameter int ADDR_BITS  = ADDR_WIDTH
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      dfi_rst_ni,
  input  logic                      dfi_cke_i,
  input  logic                      dfi_cs_ni,
  input  logic                      dfi_ras_ni,
  input  logic                      dfi_cas_ni,
  input  logic                      dfi_we_ni,
  input  logic                      dfi_odt_i,
  input  logic [2:0]                dfi_bank_i,
  input  logic [ADDR_BITS-1:0]      dfi_addr_i,
  input  logic                      dfi_wstb_i,
  input  logic                      dfi_wren_i,
  input  logic [DDR3_WIDTH/4-1:0]   dfi_mask_i,
  input  logic [2*DDR3_WIDTH-1:0]   dfi_data_i,
  input  logic                      dfi_rden_i,
  output logic                      dfi_rvld_o,
  output logic                      dfi_last_o,
  output logic [2*DDR3_WIDTH-1:0]   dfi_data_o,
  output logic                      ddr3_ck_po,
  output logic                      ddr3_ck_no,
  output logic                      ddr3_cke_o,
  output logic                      ddr3_rst_no,
  output logic                      ddr3_cs_no,
  output logic                      ddr3_ras_no,
  output logic                      ddr3_cas_no,
  output logic                      ddr3_we_no,
  output logic                      ddr3_odt_o,
  output logic [2:0]                ddr3_ba_o,
  output logic [ADDR_BITS-1:0]      ddr3_a_o,
  output logic [DDR3_WIDTH/8-1:0]   ddr3_dm_o,
  inout  wire  [DDR3_WIDTH/8-1:0]   ddr3_dqs_pio,
  inout  wire  [DDR3_WIDTH/8-1:0]   ddr3_dqs_nio,
  inout  wire  [DDR3_WIDTH-1:0]     ddr3_dq_io
);

  localparam int LANES = DDR3_WIDTH / 8;

  cmd_ctl_t                  cmd_q;
  logic [ADDR_BITS-1:0]      addr_q;
  logic                      wren_g;
  logic                      wstb_g;
  logic [2*LANES-1:0]        mask_g;
  logic [DDR3_WIDTH-1:0]     dq_out;
  logic [DDR3_WIDTH-1:0]     dq_en;
  logic [DDR3_WIDTH-1:0]     dq_cap;
  logic [WORD_CNT_BITS-1:0]  word_cnt;
  logic                      unused_ck_p_en;
  logic                      unused_ck_p_cap;
  logic                      unused_ck_n_en;
  logic                      unused_ck_n_cap;

  always_ff @(posedge clock) begin
    if (reset) begin
      cmd_q  <= CMD_RESET;
      addr_q <= '0;
    end else begin
      cmd_q  <= '{rst_n: dfi_rst_ni, cke: dfi_cke_i, cs_n: dfi_cs_ni, ras_n: dfi_ras_ni,
                  cas_n: dfi_cas_ni, we_n: dfi_we_ni, odt: dfi_odt_i, ba: dfi_bank_i};
      addr_q <= dfi_addr_i;
    end
  end

  assign ddr3_rst_no = cmd_q.rst_n;
  assign ddr3_cke_o  = cmd_q.cke;
  assign ddr3_cs_no  = cmd_q.cs_n;
  assign ddr3_ras_no = cmd_q.ras_n;
  assign ddr3_cas_no = cmd_q.cas_n;
  assign ddr3_we_no  = cmd_q.we_n;
  assign ddr3_odt_o  = cmd_q.odt;
  assign ddr3_ba_o   = cmd_q.ba;
  assign ddr3_a_o    = addr_q;

  // Gating with reset lets the pad registers fall back to tri-state/zero on a reset edge.
  assign wren_g = dfi_wren_i & ~reset;
  assign wstb_g = dfi_wstb_i & ~reset;
  assign mask_g = reset ? '0 : dfi_mask_i;

  ddr_io_bit u_ck_p (
    .clock(clock), .d_rise(1'b1), .d_fall(1'b0), .oe(1'b1), .hold_off(1'b0), .pad_in(1'b0),
    .pad_out(ddr3_ck_po), .pad_en(unused_ck_p_en), .cap_neg(unused_ck_p_cap)
  );

  ddr_io_bit u_ck_n (
    .clock(clock), .d_rise(1'b0), .d_fall(1'b1), .oe(1'b1), .hold_off(1'b0), .pad_in(1'b0),
    .pad_out(ddr3_ck_no), .pad_en(unused_ck_n_en), .cap_neg(unused_ck_n_cap)
  );

  // A read beat expected this cycle takes the bus from any write still in flight.
  for (genvar i = 0; i < DDR3_WIDTH; i++) begin : g_dq
    ddr_io_bit u_bit (
      .clock(clock), .d_rise(dfi_data_i[i]), .d_fall(dfi_data_i[DDR3_WIDTH+i]),
      .oe(wren_g), .hold_off(dfi_rden_i), .pad_in(ddr3_dq_io[i]),
      .pad_out(dq_out[i]), .pad_en(dq_en[i]), .cap_neg(dq_cap[i])
    );
    assign ddr3_dq_io[i] = dq_en[i] ? dq_out[i] : 1'bz;
  end

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    logic unused_dm_en;
    logic unused_dm_cap;
    logic dqs_p_out;
    logic dqs_p_en;
    logic dqs_n_out;
    logic dqs_n_en;
    logic unused_dqs_p_cap;
    logic unused_dqs_n_cap;

    ddr_io_bit u_dm (
      .clock(clock), .d_rise(mask_g[j]), .d_fall(mask_g[LANES+j]), .oe(1'b1),
      .hold_off(1'b0), .pad_in(1'b0),
      .pad_out(ddr3_dm_o[j]), .pad_en(unused_dm_en), .cap_neg(unused_dm_cap)
    );

    // Preamble holds DQS low; during data it follows CK.
    ddr_io_bit u_dqs_p (
      .clock(clock), .d_rise(wren_g), .d_fall(1'b0), .oe(wstb_g), .hold_off(1'b0),
      .pad_in(ddr3_dqs_pio[j]),
      .pad_out(dqs_p_out), .pad_en(dqs_p_en), .cap_neg(unused_dqs_p_cap)
    );

    ddr_io_bit u_dqs_n (
      .clock(clock), .d_rise(~wren_g), .d_fall(1'b1), .oe(wstb_g), .hold_off(1'b0),
      .pad_in(ddr3_dqs_nio[j]),
      .pad_out(dqs_n_out), .pad_en(dqs_n_en), .cap_neg(unused_dqs_n_cap)
    );

    assign ddr3_dqs_pio[j] = dqs_p_en ? dqs_p_out : 1'bz;
    assign ddr3_dqs_nio[j] = dqs_n_en ? dqs_n_out : 1'bz;
  end

  // Beat 1 is still on the pins at this edge; beat 0 came from the negedge capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      dfi_rvld_o <= 1'b0;
      dfi_last_o <= 1'b0;
      dfi_data_o <= '0;
      word_cnt   <= '0;
    end else begin
      dfi_rvld_o <= dfi_rden_i;
      dfi_last_o <= dfi_rden_i && (word_cnt == WORD_CNT_BITS'(BL8_WORDS - 1));
      if (dfi_rden_i) begin
        dfi_data_o <= {ddr3_dq_io, dq_cap};
        word_cnt   <= word_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ddr3_phy_generic.sv
// tb/tb_ddr3_phy_generic.sv - directed and randomized bench for ddr3_phy_generic
module tb_ddr3_phy_generic;

  logic        clock = 1'b0;
  logic        reset;
  logic        dfi_rst_ni, dfi_cke_i, dfi_cs_ni, dfi_ras_ni, dfi_cas_ni, dfi_we_ni, dfi_odt_i;
  logic [2:0]  dfi_bank_i;
  logic [13:0] dfi_addr_i;
  logic        dfi_wstb_i, dfi_wren_i, dfi_rden_i;
  logic [3:0]  dfi_mask_i;
  logic [31:0] dfi_data_i;
  logic        dfi_rvld_o, dfi_last_o;
  logic [31:0] dfi_data_o;
  logic        ddr3_ck_po, ddr3_ck_no, ddr3_cke_o, ddr3_rst_no, ddr3_cs_no;
  logic        ddr3_ras_no, ddr3_cas_no, ddr3_we_no, ddr3_odt_o;
  logic [2:0]  ddr3_ba_o;
  logic [13:0] ddr3_a_o;
  logic [1:0]  ddr3_dm_o;
  wire  [1:0]  dqs_p;
  wire  [1:0]  dqs_n;
  wire  [15:0] dq;

  logic [15:0] dq_drv;
  logic        dq_oe;
  assign dq = dq_oe ? dq_drv : 16'bz;

  int checks = 0;
  int failures = 0;
  int words_seen = 0;
  logic [31:0] wdata [4];
  logic [3:0]  wmask [4];

  always #5 clock = ~clock;

  ddr3_phy_generic dut (
    .clock(clock), .reset(reset),
    .dfi_rst_ni(dfi_rst_ni), .dfi_cke_i(dfi_cke_i), .dfi_cs_ni(dfi_cs_ni),
    .dfi_ras_ni(dfi_ras_ni), .dfi_cas_ni(dfi_cas_ni), .dfi_we_ni(dfi_we_ni),
    .dfi_odt_i(dfi_odt_i), .dfi_bank_i(dfi_bank_i), .dfi_addr_i(dfi_addr_i),
    .dfi_wstb_i(dfi_wstb_i), .dfi_wren_i(dfi_wren_i), .dfi_mask_i(dfi_mask_i),
    .dfi_data_i(dfi_data_i), .dfi_rden_i(dfi_rden_i),
    .dfi_rvld_o(dfi_rvld_o), .dfi_last_o(dfi_last_o), .dfi_data_o(dfi_data_o),
    .ddr3_ck_po(ddr3_ck_po), .ddr3_ck_no(ddr3_ck_no), .ddr3_cke_o(ddr3_cke_o),
    .ddr3_rst_no(ddr3_rst_no), .ddr3_cs_no(ddr3_cs_no), .ddr3_ras_no(ddr3_ras_no),
    .ddr3_cas_no(ddr3_cas_no), .ddr3_we_no(ddr3_we_no), .ddr3_odt_o(ddr3_odt_o),
    .ddr3_ba_o(ddr3_ba_o), .ddr3_a_o(ddr3_a_o), .ddr3_dm_o(ddr3_dm_o),
    .ddr3_dqs_pio(dqs_p), .ddr3_dqs_nio(dqs_n), .ddr3_dq_io(dq)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] pins();
    return {ddr3_rst_no, ddr3_cke_o, ddr3_cs_no, ddr3_ras_no, ddr3_cas_no,
            ddr3_we_no, ddr3_odt_o, ddr3_ba_o, ddr3_a_o};
  endfunction

  // A released bus reads back exactly what the bench drives onto it.
  task automatic check_hiz(input string tag);
    dq_oe = 1'b1;
    dq_drv = 16'h0000;
    #1 check({tag, "_lo"}, 64'(dq), 64'(16'h0000));
    dq_drv = 16'hffff;
    #1 check({tag, "_hi"}, 64'(dq), 64'(16'hffff));
    dq_oe = 1'b0;
  endtask

  task automatic run_write();
    logic        p_stb = 1'b0;
    logic        p_wren = 1'b0;
    logic [31:0] p_d = '0;
    logic [3:0]  p_m = '0;
    for (int s = 0; s <= 5; s++) begin
      @(posedge clock); #1;
      if (s <= 4) begin
        dfi_wstb_i = 1'b1;
        dfi_wren_i = (s >= 1);
        dfi_data_i = (s >= 1) ? wdata[s-1] : $urandom;
        dfi_mask_i = (s >= 1) ? wmask[s-1] : 4'h0;
      end else begin
        dfi_wstb_i = 1'b0;
        dfi_wren_i = 1'b0;
      end
      #1;
      if (p_wren) begin
        check("wr_dq_beat0", 64'(dq), 64'(p_d[15:0]));
        check("wr_dm_beat0", 64'(ddr3_dm_o), 64'(p_m[1:0]));
      end
      if (p_stb) begin
        check("wr_dqs_p_high", 64'(dqs_p), 64'(p_wren ? 2'b11 : 2'b00));
        check("wr_dqs_n_high", 64'(dqs_n), 64'(p_wren ? 2'b00 : 2'b11));
      end
      @(negedge clock); #2;
      if (p_wren) begin
        check("wr_dq_beat1", 64'(dq), 64'(p_d[31:16]));
        check("wr_dm_beat1", 64'(ddr3_dm_o), 64'(p_m[3:2]));
      end
      if (p_stb) begin
        check("wr_dqs_p_low", 64'(dqs_p), 64'(2'b00));
        check("wr_dqs_n_low", 64'(dqs_n), 64'(2'b11));
      end
      p_stb  = dfi_wstb_i;
      p_wren = dfi_wren_i;
      p_d    = dfi_data_i;
      p_m    = dfi_mask_i;
    end
  endtask

  task automatic run_read(input int n, input int rst_at, input bit pre_write);
    logic [15:0] b0, b1;
    logic [31:0] exp_word = '0;
    bit          exp_v = 1'b0;
    bit          exp_last = 1'b0;
    bit          exp_rst = 1'b0;
    if (pre_write) begin
      @(posedge clock); #1;
      dfi_wstb_i = 1'b1;
      dfi_wren_i = 1'b1;
      dfi_data_i = $urandom;
      dfi_mask_i = 4'h0;
    end
    for (int s = 0; s <= n + 1; s++) begin
      @(posedge clock); #1;
      check("rd_vld", 64'(dfi_rvld_o), 64'(exp_v));
      check("rd_last", 64'(dfi_last_o), 64'(exp_last));
      if (exp_v) check("rd_data", 64'(dfi_data_o), 64'(exp_word));
      if (exp_rst) check("rd_data_reset", 64'(dfi_data_o), 64'(32'h0));
      dfi_wstb_i = 1'b0;
      dfi_wren_i = 1'b0;
      if (s < n) begin
        reset = (s == rst_at);
        dfi_rden_i = 1'b1;
        b0 = 16'($urandom);
        b1 = 16'($urandom);
        dq_drv = b0;
        dq_oe = 1'b1;
        exp_rst = reset;
        if (reset) begin
          exp_v = 1'b0;
          exp_last = 1'b0;
          words_seen = 0;
        end else begin
          exp_v = 1'b1;
          exp_word = {b1, b0};
          exp_last = (words_seen % 4) == 3;
          words_seen++;
        end
        @(negedge clock); #1;
        dq_drv = b1;
      end else begin
        reset = 1'b0;
        dfi_rden_i = 1'b0;
        dq_oe = 1'b0;
        exp_v = 1'b0;
        exp_last = 1'b0;
        exp_rst = 1'b0;
      end
    end
  endtask

  initial begin
    logic [23:0] r, prev;

    reset = 1'b1;
    dfi_rst_ni = 1'b1; dfi_cke_i = 1'b1; dfi_cs_ni = 1'b0; dfi_ras_ni = 1'b0;
    dfi_cas_ni = 1'b0; dfi_we_ni = 1'b0; dfi_odt_i = 1'b1;
    dfi_bank_i = 3'd7; dfi_addr_i = 14'h2aaa;
    dfi_wstb_i = 1'b0; dfi_wren_i = 1'b0; dfi_rden_i = 1'b0;
    dfi_mask_i = 4'hf; dfi_data_i = 32'hdeadbeef;
    dq_drv = 16'h0; dq_oe = 1'b0;

    repeat (3) @(posedge clock);
    #1;
    check("reset_cmd_pins", 64'(pins()), 64'({1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 14'd0}));
    check("reset_rvld", 64'(dfi_rvld_o), 64'(1'b0));
    check("reset_last", 64'(dfi_last_o), 64'(1'b0));
    check("reset_rdata", 64'(dfi_data_o), 64'(32'h0));
    check("reset_dm", 64'(ddr3_dm_o), 64'(2'b00));
    check_hiz("reset_dq_hiz");

    @(posedge clock); #1;
    reset = 1'b0;
    dfi_cke_i = 1'b1; dfi_cs_ni = 1'b1; dfi_ras_ni = 1'b1; dfi_cas_ni = 1'b1;
    dfi_we_ni = 1'b1; dfi_odt_i = 1'b0; dfi_bank_i = 3'd0; dfi_addr_i = 14'd0;
    dfi_mask_i = 4'h0; dfi_data_i = 32'h0;
    #1 check("rst_n_before_edge", 64'(ddr3_rst_no), 64'(1'b0));
    @(posedge clock); #1;
    check("rst_n_after_1", 64'(ddr3_rst_no), 64'(1'b1));

    @(posedge clock); #2;
    check("ck_p_high", 64'(ddr3_ck_po), 64'(1'b1));
    check("ck_n_high", 64'(ddr3_ck_no), 64'(1'b0));
    @(negedge clock); #2;
    check("ck_p_low", 64'(ddr3_ck_po), 64'(1'b0));
    check("ck_n_low", 64'(ddr3_ck_no), 64'(1'b1));

    @(posedge clock); #1;
    prev = pins();
    dfi_cs_ni = 1'b0; dfi_ras_ni = 1'b0; dfi_cas_ni = 1'b1; dfi_we_ni = 1'b1;
    dfi_bank_i = 3'd5; dfi_addr_i = 14'h1a3;
    #1 check("act_hold", 64'(ddr3_ras_no), 64'(1'b1));
    @(posedge clock); #1;
    check("act_pins", 64'(pins()), 64'({1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd5, 14'h1a3}));

    prev = {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd5, 14'h1a3};
    for (int i = 0; i < 6; i++) begin
      @(posedge clock); #1;
      r = 24'($urandom);
      {dfi_rst_ni, dfi_cke_i, dfi_cs_ni, dfi_ras_ni, dfi_cas_ni, dfi_we_ni,
       dfi_odt_i, dfi_bank_i, dfi_addr_i} = r;
      #1 check("cmd_hold", 64'(pins()), 64'(prev));
      @(posedge clock); #1;
      check("cmd_latency", 64'(pins()), 64'(r));
      prev = r;
    end

    dfi_rst_ni = 1'b1; dfi_cke_i = 1'b1; dfi_cs_ni = 1'b1; dfi_ras_ni = 1'b1;
    dfi_cas_ni = 1'b1; dfi_we_ni = 1'b1; dfi_odt_i = 1'b0;

    wdata[0] = 32'h11112222; wdata[1] = 32'h33334444;
    wdata[2] = 32'h55556666; wdata[3] = 32'h77778888;
    for (int i = 0; i < 4; i++) wmask[i] = 4'h0;
    run_write();
    @(posedge clock); #1;
    check_hiz("post_write_dq_hiz");

    wdata[0] = $urandom;
    wmask[0] = 4'b0010;
    for (int i = 1; i < 4; i++) begin
      wdata[i] = $urandom;
      wmask[i] = 4'($urandom);
    end
    run_write();

    run_read(4, -1, 1'b1);
    run_read(8, -1, 1'b0);
    run_read(8, 5, 1'b0);
    run_read(4, -1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ddr3_phy_generic.md
Name: ddr3_phy_generic

Overview:
- Vendor-neutral DDR3 PHY sitting between the DFI port of the AXI DDR3-lite controller and the x16 DDR3 SDRAM pins.
- Registers the command/address path and serialises 32-bit DFI write words into two 16-bit DQ beats per clock.
- Deserialises read beats back into 32-bit DFI words with valid/last flags.
- Uses a single clock; double-data-rate transfer uses both edges of `clock`. The required PHY_WR_DELAY and PHY_RD_DELAY settings in the controller are both 1.

Parameters:
- DDR3_WIDTH, 16: DQ pin width. Must be a multiple of 8. The DFI data width is 2*DDR3_WIDTH; the DFI mask width is DDR3_WIDTH/4.
- ADDR_BITS, 14: DDR3 row/address pin width.

Ports:
Clock, reset and command path:
- clock  in  1  controller/PHY clock; forwarded as the DDR3 CK.
- reset  in  1  synchronous, active-high reset.
- dfi_rst_ni, dfi_cke_i, dfi_cs_ni, dfi_ras_ni, dfi_cas_ni, dfi_we_ni, dfi_odt_i  in  1 each  DFI command signals.
- dfi_bank_i  in  3  bank address.
- dfi_addr_i  in  ADDR_BITS  row/column address.

Write path:
- dfi_wstb_i  in  1  DQS drive enable; covers preamble plus burst.
- dfi_wren_i  in  1  write data valid.
- dfi_mask_i  in  DDR3_WIDTH/4  byte masks; 1 = byte masked.
- dfi_data_i  in  2*DDR3_WIDTH  write word; the low half is beat 0.

Read path:
- dfi_rden_i  in  1  read beat expected on DQ this cycle.
- dfi_rvld_o  out  1  read word valid.
- dfi_last_o  out  1  last word of a BL8 burst.
- dfi_data_o  out  2*DDR3_WIDTH  read word; beat 0 in the low half.

DDR3 pins:
- ddr3_ck_po, ddr3_ck_no  out  1 each  differential clock.
- ddr3_cke_o, ddr3_rst_no, ddr3_cs_no, ddr3_ras_no, ddr3_cas_no, ddr3_we_no, ddr3_odt_o  out  1 each.
- ddr3_ba_o  out  3.
- ddr3_a_o  out  ADDR_BITS.
- ddr3_dm_o  out  DDR3_WIDTH/8.
- ddr3_dqs_pio, ddr3_dqs_nio  inout  DDR3_WIDTH/8 each.
- ddr3_dq_io  inout  DDR3_WIDTH.

Behaviour:
Clock and command path:
- ddr3_ck_po = clock; ddr3_ck_no = ~clock, produced through a DDR output cell.
- All command/address pins are registered on posedge clock, giving a latency of exactly 1 cycle.

Reset values (sampled at posedge while reset=1):
- rst_no=0, cke=0, cs_no=1, ras_no=1, cas_no=1, we_no=1, odt=0, ba=0, a=0, dm=0.
- DQ and DQS/DQS_n are high-Z.
- dfi_rvld_o=0, dfi_last_o=0, dfi_data_o=0.
- The read beat counter is cleared.
- Reset mid-burst aborts immediately: pins are tri-stated and no further rvld is produced.

Write path:
- wren at cycle n puts the data on DQ during cycle n+1, giving a latency of 1.
  - Beat 0 (data[DDR3_WIDTH-1:0], mask low half) is driven while clock is high.
  - Beat 1 (upper half) is driven while clock is low.
- dm follows the same beat order.
- DQ output enable is wren delayed by 1.
- DQS output enable is wstb delayed by 1.
- DQS polarity and toggling:
  - DQS_p is held low in cycles where the delayed wstb=1 and the delayed wren=0 (the preamble).
  - DQS_p = clock where the delayed wren=1.
  - DQS_n = ~DQS_p.
- DQ/DQS edges are aligned to the CK edges. Centring of DQ in the DQS eye is left to external IO delay.
- When wren is deasserted, DQ returns to high-Z in the following cycle.

Read path:
- The read path samples DQ with clock, not DQS.
  - Beat 0 is captured at the negedge within the cycle where rden=1.
  - Beat 1 is captured at the following posedge.
- A cycle with rden=1 at n produces dfi_rvld_o=1 at n+1, with dfi_data_o = {beat1, beat0}. Read latency is 1.
- A 2-bit word counter increments on each valid word. dfi_last_o=1 on the 4th word (counter==3), then the counter wraps to 0.
- Back-to-back bursts must be seamless.
- When rden=1 while the write DQ enable is active, the read wins and the DQ drivers are disabled.

Decomposition:
- Shared package ddr3_phy_pkg holds:
  - the width constants (DQ, DM = DDR3_WIDTH/8, DFI data = 2*DDR3_WIDTH, DFI mask = DDR3_WIDTH/4);
  - the PHY_WR_DELAY=1 and PHY_RD_DELAY=1 constants;
  - BL8_WORDS=4.
- One natural sub-module, ddr_io_bit: a per-pin DDR output register, DDR input capture and tristate. It is instantiated for every DQ, DM and DQS pin and for CK.

Test Plan:
1. Reset: hold reset 3 cycles → cke=0, rst_no=0, cs_no=1, dq='z', rvld=0. Release reset with dfi_rst_ni=1 → ddr3_rst_no=1 after exactly 1 cycle.
2. Command: drive ACT with bank=5, addr=0x1A3 at cycle n → at cycle n+1, ras_no=0, cas_no=1, we_no=1, ba=5, a=0x1A3.
3. Write BL8:
   - Stimulus: wstb for 5 cycles (1 preamble plus 4 data); wren over 4 cycles with data 0x11112222, 0x33334444, 0x55556666, 0x77778888 and mask=0.
   - Required DQ sequence: 2222, 1111, 4444, 3333, and so on, starting the cycle after each wren.
   - DQS is low during the preamble and then toggles with clock; dm=0.
4. Masked write: mask=4'b0010 → dm[1]=1 during beat 0 only.
5. Read BL8:
   - Stimulus: model drives DQ beats A0..A7 over 4 rden cycles.
   - Required: rvld for 4 cycles starting at cycle n+1, data={A1,A0}…{A7,A6}, last=1 only on the 4th word.
6. Two back-to-back read bursts (8 rden cycles) → 8 rvld words, last on words 4 and 8. A reset asserted during the second burst → rvld=0 on the next cycle.
